// File: rtl/universal_shift_reg.sv
// ---------------------------------------------------------------------------
// universal_shift_reg
//
// Parametrised universal shift register with a burst engine.
//
// Each step applies one of eight modes to the register:
//    HOLD, SHR (serial in at MSB), SHL (serial in at LSB), LOAD,
//    ROR, ROL, ASR (MSB replicated), CLEAR.
//
// In IDLE a single step is applied on any edge where en is high. A start
// pulse instead launches a burst of burst_len consecutive steps of the mode
// sampled with start. busy is high for the whole burst, and done pulses for
// one cycle when the burst completes.
//
// Ports
//    clk        in   1      clock, rising edge
//    rst        in   1      asynchronous active-high reset
//    en         in   1      single-step enable (IDLE only)
//    mode       in   3      step mode (see mode_e)
//    sin        in   1      serial input for SHR/SHL, sampled every step
//    load_data  in   WIDTH  parallel data for LOAD, sampled every step
//    start      in   1      burst request (IDLE only)
//    burst_len  in   CNT_W  number of burst steps, sampled with start
//    q          out  WIDTH  register contents
//    sout_r     out  1      q[0], the bit leaving on the next SHR/ROR/ASR
//    sout_l     out  1      q[WIDTH-1], the bit leaving on the next SHL/ROL
//    busy       out  1      high while a burst is running
//    done       out  1      one-cycle pulse when a burst completes
// ---------------------------------------------------------------------------
module universal_shift_reg #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic             sin,
   input  logic [WIDTH-1:0] load_data,
   input  logic             start,
   input  logic [CNT_W-1:0] burst_len,
   output logic [WIDTH-1:0] q,
   output logic             sout_r,
   output logic             sout_l,
   output logic             busy,
   output logic             done
);

   typedef enum logic [2:0] {
      M_HOLD  = 3'd0,
      M_SHR   = 3'd1,
      M_SHL   = 3'd2,
      M_LOAD  = 3'd3,
      M_ROR   = 3'd4,
      M_ROL   = 3'd5,
      M_ASR   = 3'd6,
      M_CLEAR = 3'd7
   } mode_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BURST = 2'd1,
      S_DONE  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       mode_r_q, mode_r_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // One step of the register for a given mode.
   function automatic logic [WIDTH-1:0] step_f(
      input logic [2:0]       m,
      input logic [WIDTH-1:0] cur,
      input logic             s_in,
      input logic [WIDTH-1:0] ld
   );
      logic [WIDTH-1:0] r;
      r = cur;
      case (mode_e'(m))
         M_HOLD:  r = cur;
         M_SHR:   r = {s_in, cur[WIDTH-1:1]};
         M_SHL:   r = {cur[WIDTH-2:0], s_in};
         M_LOAD:  r = ld;
         M_ROR:   r = {cur[0], cur[WIDTH-1:1]};
         M_ROL:   r = {cur[WIDTH-2:0], cur[WIDTH-1]};
         M_ASR:   r = {cur[WIDTH-1], cur[WIDTH-1:1]};
         M_CLEAR: r = '0;
         default: r = cur;
      endcase
      return r;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         q_q      <= '0;
         cnt_q    <= '0;
         mode_r_q <= 3'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         q_q      <= q_d;
         cnt_q    <= cnt_d;
         mode_r_q <= mode_r_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      q_d      = q_q;
      cnt_d    = cnt_q;
      mode_r_d = mode_r_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               // A zero-length burst still produces its done pulse.
               if (burst_len == '0) begin
                  state_d = S_DONE;
               end else begin
                  state_d  = S_BURST;
                  mode_r_d = mode;
                  cnt_d    = burst_len;
               end
            end else if (en) begin
               q_d = step_f(mode, q_q, sin, load_data);
            end
         end
         S_BURST: begin
            q_d   = step_f(mode_r_q, q_q, sin, load_data);
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Status flags are registered copies of the next state so that they
      // come straight out of flops.
      busy_d = (state_d == S_BURST);
      done_d = (state_d == S_DONE);
   end

   assign q      = q_q;
   assign sout_r = q_q[0];
   assign sout_l = q_q[WIDTH-1];
   assign busy   = busy_q;
   assign done   = done_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// ---------------------------------------------------------------------------
// tb_universal_shift_reg
//
// Directed bench for universal_shift_reg (WIDTH=8, CNT_W=4). Inputs change
// and outputs are sampled 1 ns after each rising clock edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_universal_shift_reg;

   localparam int WIDTH = 8;
   localparam int CNT_W = 4;

   localparam logic [2:0] HOLD  = 3'd0;
   localparam logic [2:0] SHR   = 3'd1;
   localparam logic [2:0] SHL   = 3'd2;
   localparam logic [2:0] LOAD  = 3'd3;
   localparam logic [2:0] ROR   = 3'd4;
   localparam logic [2:0] ROL   = 3'd5;
   localparam logic [2:0] ASR   = 3'd6;
   localparam logic [2:0] CLEAR = 3'd7;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             en = 1'b0;
   logic [2:0]       mode = 3'd0;
   logic             sin = 1'b0;
   logic [WIDTH-1:0] load_data = '0;
   logic             start = 1'b0;
   logic [CNT_W-1:0] burst_len = '0;
   logic [WIDTH-1:0] q;
   logic             sout_r, sout_l, busy, done;

   int compared = 0;
   int mismatched = 0;

   universal_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .sin(sin),
      .load_data(load_data), .start(start), .burst_len(burst_len),
      .q(q), .sout_r(sout_r), .sout_l(sout_l), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Single IDLE step: drive en/mode, take one edge, release en.
   task automatic single_step(input logic [2:0] m, input logic s,
                              input logic [WIDTH-1:0] ld);
      en = 1'b1; mode = m; sin = s; load_data = ld;
      tick();
      en = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      compared++;
      if ({q, sout_r, sout_l, busy, done} !== {8'h00, 4'b0000}) begin
         mismatched++;
         $display("FAIL reset_state: got q=%h sr=%b sl=%b busy=%b done=%b, want 00 0 0 0 0",
                  q, sout_r, sout_l, busy, done);
      end
      rst = 1'b0;
      tick();
      $display("reset: q=%h busy=%b done=%b", q, busy, done);
   endtask

   task automatic test_shift();
      single_step(LOAD, 1'b0, 8'hA5);
      compared++;
      if (q !== 8'hA5) begin
         mismatched++; $display("FAIL load: got %h want a5", q);
      end
      single_step(SHR, 1'b1, 8'h00);
      compared++;
      if (q !== 8'hD2) begin
         mismatched++; $display("FAIL shr: got %h want d2", q);
      end
      single_step(SHL, 1'b0, 8'h00);
      compared++;
      if ({q, sout_r, sout_l} !== {8'hA4, 1'b0, 1'b1}) begin
         mismatched++;
         $display("FAIL shl: got q=%h sr=%b sl=%b want a4 0 1", q, sout_r, sout_l);
      end
      // en low: register must hold whatever the mode
      mode = CLEAR; en = 1'b0;
      tick();
      compared++;
      if (q !== 8'hA4) begin
         mismatched++; $display("FAIL en_low_hold: got %h want a4", q);
      end
      $display("shift: q=%h", q);
   endtask

   task automatic test_rotate();
      single_step(LOAD, 1'b0, 8'h81);
      single_step(ROL, 1'b0, 8'h00);
      compared++;
      if (q !== 8'h03) begin
         mismatched++; $display("FAIL rol: got %h want 03", q);
      end
      single_step(ROR, 1'b0, 8'h00);
      compared++;
      if (q !== 8'h81) begin
         mismatched++; $display("FAIL ror: got %h want 81", q);
      end
      single_step(ASR, 1'b0, 8'h00);
      compared++;
      if (q !== 8'hC0) begin
         mismatched++; $display("FAIL asr: got %h want c0", q);
      end
      single_step(HOLD, 1'b1, 8'hFF);
      compared++;
      if (q !== 8'hC0) begin
         mismatched++; $display("FAIL hold: got %h want c0", q);
      end
      single_step(CLEAR, 1'b1, 8'hFF);
      compared++;
      if (q !== 8'h00) begin
         mismatched++; $display("FAIL clear: got %h want 00", q);
      end
      $display("rotate: q=%h", q);
   endtask

   task automatic test_burst_rol();
      logic [WIDTH-1:0] exp_q [3];
      exp_q[0] = 8'h02; exp_q[1] = 8'h04; exp_q[2] = 8'h08;
      single_step(LOAD, 1'b0, 8'h01);
      start = 1'b1; mode = ROL; burst_len = 4'd3;
      tick();
      compared++;
      if ({q, busy, done} !== {8'h01, 1'b1, 1'b0}) begin
         mismatched++;
         $display("FAIL burst_accept: got q=%h busy=%b done=%b want 01 1 0", q, busy, done);
      end
      // These must all be ignored while the burst runs.
      start = 1'b0; mode = CLEAR; en = 1'b1; burst_len = 4'd9;
      for (int i = 0; i < 3; i++) begin
         tick();
         compared++;
         if ({q, busy, done} !== {exp_q[i], (i < 2), (i == 2)}) begin
            mismatched++;
            $display("FAIL burst_rol_step%0d: got q=%h busy=%b done=%b want %h %b %b",
                     i, q, busy, done, exp_q[i], (i < 2), (i == 2));
         end
      end
      // DONE cycle also ignores en.
      tick();
      compared++;
      if ({q, busy, done} !== {8'h08, 1'b0, 1'b0}) begin
         mismatched++;
         $display("FAIL burst_after_done: got q=%h busy=%b done=%b want 08 0 0", q, busy, done);
      end
      en = 1'b0;
      $display("burst_rol: q=%h", q);
   endtask

   task automatic test_zero_len();
      start = 1'b1; burst_len = 4'd0; mode = CLEAR;
      tick();
      compared++;
      if ({q, busy, done} !== {8'h08, 1'b0, 1'b1}) begin
         mismatched++;
         $display("FAIL zero_len_done: got q=%h busy=%b done=%b want 08 0 1", q, busy, done);
      end
      // start still high in DONE is ignored
      burst_len = 4'd3;
      tick();
      compared++;
      if ({q, busy, done} !== {8'h08, 1'b0, 1'b0}) begin
         mismatched++;
         $display("FAIL zero_len_after: got q=%h busy=%b done=%b want 08 0 0", q, busy, done);
      end
      start = 1'b0;
      $display("zero_len: q=%h", q);
   endtask

   task automatic test_burst_shr();
      logic [WIDTH-1:0] exp;
      single_step(CLEAR, 1'b0, 8'h00);
      start = 1'b1; mode = SHR; burst_len = 4'd8; sin = 1'b1;
      tick();
      start = 1'b0;
      exp = 8'h00;
      for (int i = 0; i < 8; i++) begin
         tick();
         exp = {1'b1, exp[WIDTH-1:1]};
         compared++;
         if ({q, busy, done} !== {exp, (i < 7), (i == 7)}) begin
            mismatched++;
            $display("FAIL burst_shr_step%0d: got q=%h busy=%b done=%b want %h %b %b",
                     i, q, busy, done, exp, (i < 7), (i == 7));
         end
      end
      tick();
      $display("burst_shr: q=%h", q);
   endtask

   task automatic test_burst_abort();
      single_step(CLEAR, 1'b0, 8'h00);
      start = 1'b1; mode = SHR; burst_len = 4'd8; sin = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      compared++;
      if ({q, busy} !== {8'hF0, 1'b1}) begin
         mismatched++;
         $display("FAIL abort_pre: got q=%h busy=%b want f0 1", q, busy);
      end
      // Asynchronous: effect visible well before the next edge.
      rst = 1'b1;
      #1;
      compared++;
      if ({q, busy, done} !== {8'h00, 1'b0, 1'b0}) begin
         mismatched++;
         $display("FAIL async_reset: got q=%h busy=%b done=%b want 00 0 0", q, busy, done);
      end
      tick();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         compared++;
         if ({q, busy, done} !== {8'h00, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL abort_no_done%0d: got q=%h busy=%b done=%b want 00 0 0",
                     i, q, busy, done);
         end
      end
      $display("burst_abort: q=%h", q);
   endtask

   // N > WIDTH: ROR by 9 equals ROR by 1.
   task automatic test_long_burst();
      int cycles;
      single_step(LOAD, 1'b0, 8'h96);
      start = 1'b1; mode = ROR; burst_len = 4'd9;
      tick();
      start = 1'b0;
      cycles = 0;
      while (done !== 1'b1 && cycles < 20) begin
         tick();
         cycles++;
      end
      compared++;
      if (cycles != 9) begin
         mismatched++;
         $display("FAIL long_burst_len: got %0d steps want 9", cycles);
      end
      compared++;
      if (q !== 8'h4B) begin
         mismatched++; $display("FAIL long_burst_q: got %h want 4b", q);
      end
      tick();
      $display("long_burst: q=%h steps=%0d", q, cycles);
   endtask

   initial begin
      test_reset();
      test_shift();
      test_rotate();
      test_burst_rol();
      test_zero_len();
      test_burst_shr();
      test_burst_abort();
      test_long_burst();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
